// File: rtl/clz_arbiter_if.sv
// Request/response bundle for the shared count-leading-zeros unit.
// slave is the arbiter side, master is the requester/consumer side.
interface clz_arbiter_if #(
    parameter int TAG_W = 4
);
    logic             req0_valid;
    logic [31:0]      req0_data;
    logic [TAG_W-1:0] req0_tag;
    logic             req0_ready;
    logic             req1_valid;
    logic [31:0]      req1_data;
    logic [TAG_W-1:0] req1_tag;
    logic             req1_ready;
    logic             rsp_valid;
    logic             rsp_ready;
    logic             rsp_id;
    logic [TAG_W-1:0] rsp_tag;
    logic [5:0]       rsp_count;
    logic [31:0]      rsp_norm;
    logic             rsp_zero;
    logic             busy;

    modport slave (
        input  req0_valid, req0_data, req0_tag,
        input  req1_valid, req1_data, req1_tag,
        input  rsp_ready,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_id, rsp_tag, rsp_count, rsp_norm, rsp_zero,
        output busy
    );

    modport master (
        output req0_valid, req0_data, req0_tag,
        output req1_valid, req1_data, req1_tag,
        output rsp_ready,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_id, rsp_tag, rsp_count, rsp_norm, rsp_zero,
        input  busy
    );
endinterface

// File: rtl/clz_arbiter.sv
// Two-requester arbiter in front of a single count-leading-zeros / normalize
// datapath; one transaction in flight, IDLE -> CALC -> RESP per request.
module clz_arbiter #(
    parameter bit RR_EN = 1'b1,
    parameter int TAG_W = 4
) (
    input logic          clk,
    input logic          reset_n,
    clz_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state_q;
    logic             last_grant_q;
    logic [31:0]      op_q;
    logic [TAG_W-1:0] tag_q;
    logic             id_q;

    logic             rsp_valid_q;
    logic             rsp_id_q;
    logic [TAG_W-1:0] rsp_tag_q;
    logic [5:0]       rsp_count_q;
    logic [31:0]      rsp_norm_q;
    logic             rsp_zero_q;

    logic             grant;
    logic             accept;
    logic [5:0]       count_d;
    logic [31:0]      norm_d;
    logic             zero_d;

    // With both requesters pending, round-robin favours the one not served last.
    always_comb begin
        grant = 1'b0;
        if (bus.req0_valid && bus.req1_valid) begin
            grant = RR_EN ? ~last_grant_q : 1'b0;
        end else if (bus.req1_valid) begin
            grant = 1'b1;
        end
    end

    assign accept = (state_q == IDLE) &&
                    ((!grant && bus.req0_valid) || (grant && bus.req1_valid));

    assign bus.req0_ready = (state_q == IDLE) && !grant;
    assign bus.req1_ready = (state_q == IDLE) &&  grant;

    // Ascending scan: the highest set bit is the last one to overwrite the count.
    always_comb begin
        count_d = 6'd32;
        for (int unsigned i = 0; i < 32; i++) begin
            if (op_q[i]) begin
                count_d = 6'(31 - i);
            end
        end
        norm_d = op_q << count_d;
        zero_d = (op_q == '0);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            op_q         <= '0;
            tag_q        <= '0;
            id_q         <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_tag_q    <= '0;
            rsp_count_q  <= '0;
            rsp_norm_q   <= '0;
            rsp_zero_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        op_q    <= grant ? bus.req1_data : bus.req0_data;
                        tag_q   <= grant ? bus.req1_tag  : bus.req0_tag;
                        id_q    <= grant;
                        state_q <= CALC;
                    end
                end
                CALC: begin
                    rsp_count_q <= count_d;
                    rsp_norm_q  <= norm_d;
                    rsp_zero_q  <= zero_d;
                    rsp_id_q    <= id_q;
                    rsp_tag_q   <= tag_q;
                    rsp_valid_q <= 1'b1;
                    state_q     <= RESP;
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q  <= 1'b0;
                        last_grant_q <= rsp_id_q;
                        state_q      <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_tag   = rsp_tag_q;
    assign bus.rsp_count = rsp_count_q;
    assign bus.rsp_norm  = rsp_norm_q;
    assign bus.rsp_zero  = rsp_zero_q;
    assign bus.busy      = (state_q != IDLE);

endmodule

// File: doc/clz_arbiter.md
Name: clz_arbiter

Overview:
Shares one count-leading-zeros datapath between two requesters: the execute-stage CLZ instruction and the divider/normalization sequencer. Arbitrates with valid/ready handshakes, computes the leading-zero count and the left-normalized operand over a fixed multi-cycle sequence, and returns a tagged response. One transaction in flight at a time.

Parameters:
RR_EN, 1, 1 = round-robin arbitration between requesters; 0 = fixed priority (req0 always wins).
TAG_W, 4, width of the requester tag carried through to the response.

Ports:
clk  input  1  system clock, all state updates on rising edge.
reset_n  input  1  synchronous active-low reset.
req0_valid  input  1  requester 0 has an operand.
req0_data  input  32  requester 0 operand.
req0_tag  input  TAG_W  requester 0 tag, returned unchanged.
req0_ready  output  1  requester 0 operand accepted this cycle when valid is also high.
req1_valid  input  1  requester 1 has an operand.
req1_data  input  32  requester 1 operand.
req1_tag  input  TAG_W  requester 1 tag.
req1_ready  output  1  requester 1 accept.
rsp_valid  output  1  response available.
rsp_ready  input  1  consumer takes response.
rsp_id  output  1  index of the requester served (0/1).
rsp_tag  output  TAG_W  tag of the served request.
rsp_count  output  6  leading-zero count, 0..32.
rsp_norm  output  32  operand shifted left by rsp_count.
rsp_zero  output  1  operand was all zeros.
busy  output  1  high whenever state is not IDLE.

Behaviour:
- Reset (reset_n low at a clock edge): state=IDLE, last_grant=1, rsp_valid=0, rsp_id=0, rsp_tag=0, rsp_count=0, rsp_norm=0, rsp_zero=0. Any in-flight transaction is discarded; nothing is emitted for it.
- FSM: IDLE -> CALC -> RESP -> IDLE.
- IDLE: grant is combinational. Only req0 valid -> grant 0. Only req1 valid -> grant 1. Both valid with RR_EN=1 -> grant the requester that is not last_grant. Both valid with RR_EN=0 -> grant 0.
- reqN_ready = (state==IDLE) && (grant==N). The ungranted requester's ready is 0. Ready may depend combinationally on valid.
- On an accept handshake, the operand, tag and id are captured into internal registers and state moves to CALC.
- CALC (exactly one cycle):
  - count = number of zero bits above the most-significant 1, scanning from bit 31 down. Range 0..32; 32 when operand==0.
  - norm = operand << count, zero-filled; norm=0 when count=32.
  - zero = (operand==0).
  - Results are registered into the rsp_* outputs, rsp_valid is set to 1, and state moves to RESP.
- RESP: rsp_* are held stable while rsp_valid=1 && rsp_ready=0. On rsp_valid && rsp_ready, at the same edge: rsp_valid clears, last_grant updates to rsp_id, and state returns to IDLE.
- Latency: accept at edge N -> rsp_valid high after edge N+1. Earliest next accept is in the cycle after response handshake. Minimum 3 cycles per transaction.
- rsp_ready held high continuously gives throughput of one result per 3 cycles, with no bubbles added beyond that.
- last_grant changes only on response completion, never on accept.
- A requester whose valid drops before ready is simply not served. Requesters must hold data/tag stable while valid && !ready; the block does not check this.
- busy = (state != IDLE).

Test Plan:
- Reset: hold reset_n=0 for 2 cycles with both valids high -> after release all rsp_* = 0, busy=0. First contention grants req0, since last_grant resets to 1.
- Single request: req0 data=32'h0001_0000, tag=3, rsp_ready=1 -> rsp_valid one cycle after accept with count=15, norm=32'h8000_0000, zero=0, id=0, tag=3.
- Boundary values, with rsp_ready=1:
  - 32'h8000_0000 -> count=0, norm unchanged.
  - 32'h0000_0001 -> count=31, norm=32'h8000_0000.
  - 32'h0 -> count=32, norm=0, zero=1.
- Round-robin contention (RR_EN=1): both valids held high for 4 transactions -> grants alternate 0,1,0,1. The unselected requester's ready stays 0 throughout.
- Backpressure: rsp_ready=0 for 5 cycles after rsp_valid -> outputs stable, both readys 0, busy=1. Raising rsp_ready completes the transaction, and a new accept occurs the next cycle.
- Reset mid-operation: assert reset_n=0 during CALC -> no response is produced and state=IDLE. With RR_EN=0 and both valid, req0 always wins.
